dlfloat_round_pipe: RTL and testbench



---
 rtl/dlfloat_round_pipe.sv | 174 +++++++++++++++++
 tb/tb_dlfloat_round_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_round_pipe.sv
// Two-stage rounding pipeline for DLfloat results: S1 decodes guard/round/sticky
// and decides the increment, S2 applies it and detects overflow.
module dlfloat_round_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int XTR_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_W+MAN_W+XTR_W:0]     in_data,
    input  logic [2:0]                     in_rm,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_W+MAN_W:0]           out_data,
    output logic [2:0]                     out_flags,
    output logic [2:0]                     acc_flags,
    input  logic                           clr_flags
);

    // Returns {bad_rm, inc}; reserved modes fall back to round-to-nearest-even.
    function automatic logic [1:0] round_decide(
        input logic [2:0] rm,
        input logic       sign,
        input logic       g,
        input logic       r,
        input logic       s,
        input logic       l
    );
        logic nx;
        nx = g | r | s;
        case (rm)
            3'b000:  round_decide = {1'b0, g & (r | s | l)};
            3'b001:  round_decide = {1'b0, 1'b0};
            3'b010:  round_decide = {1'b0, ~sign & nx};
            3'b011:  round_decide = {1'b0, sign & nx};
            3'b100:  round_decide = {1'b0, g};
            default: round_decide = {1'b1, g & (r | s | l)};
        endcase
    endfunction

    logic                  in_sign_s;
    logic [EXP_W-1:0]      in_exp_s;
    logic [MAN_W-1:0]      in_mant_s;
    logic [XTR_W-1:0]      in_xtr_s;
    logic                  in_special_s;
    logic [1:0]            dec_s;
    logic                  inc_s;
    logic                  inexact_s;

    logic                  s1_valid_r;
    logic                  s1_sign_r;
    logic [EXP_W-1:0]      s1_exp_r;
    logic [MAN_W-1:0]      s1_mant_r;
    logic                  s1_inc_r;
    logic                  s1_inexact_r;
    logic                  s1_bad_rm_r;
    logic                  s1_special_r;

    logic [MAN_W:0]        sum_s;
    logic [EXP_W-1:0]      res_exp_s;
    logic [MAN_W-1:0]      res_mant_s;
    logic                  ovf_s;
    logic [EXP_W+MAN_W:0]  res_data_s;

    logic                  s2_valid_r;
    logic [EXP_W+MAN_W:0]  out_data_r;
    logic [2:0]            out_flags_r;
    logic [2:0]            acc_flags_r;

    logic                  s2_adv_s;
    logic                  s1_adv_s;
    logic                  out_xfer_s;

    assign in_sign_s = in_data[EXP_W+MAN_W+XTR_W];
    assign in_exp_s  = in_data[EXP_W+MAN_W+XTR_W-1 -: EXP_W];
    assign in_mant_s = in_data[MAN_W+XTR_W-1 -: MAN_W];
    assign in_xtr_s  = in_data[XTR_W-1:0];

    assign s2_adv_s   = ~s2_valid_r | out_ready;
    assign s1_adv_s   = ~s1_valid_r | s2_adv_s;
    assign in_ready   = ~rst & s1_adv_s;
    assign out_xfer_s = s2_valid_r & out_ready;

    assign out_valid  = s2_valid_r;
    assign out_data   = out_data_r;
    assign out_flags  = out_flags_r;
    assign acc_flags  = acc_flags_r;

    // S1 decode: increment decision and inexact, suppressed for Inf/NaN encodings.
    always_comb begin
        in_special_s = (&in_exp_s) & (&in_mant_s);
        dec_s = round_decide(in_rm, in_sign_s, in_xtr_s[XTR_W-1], in_xtr_s[XTR_W-2],
                             |in_xtr_s[XTR_W-3:0], in_mant_s[0]);
        if (in_special_s) begin
            inc_s     = 1'b0;
            inexact_s = 1'b0;
        end else begin
            inc_s     = dec_s[0];
            inexact_s = |in_xtr_s;
        end
    end

    assign sum_s = {1'b0, s1_mant_r} + {{MAN_W{1'b0}}, s1_inc_r};

    // S2 apply: mantissa carry bumps the exponent; landing on all-ones saturates as overflow.
    always_comb begin
        if (sum_s[MAN_W]) begin
            res_mant_s = {MAN_W{1'b0}};
            res_exp_s  = s1_exp_r + {{(EXP_W-1){1'b0}}, 1'b1};
        end else begin
            res_mant_s = sum_s[MAN_W-1:0];
            res_exp_s  = s1_exp_r;
        end
        ovf_s = ~s1_special_r & (&res_exp_s) & (&res_mant_s);
        if (ovf_s) begin
            res_data_s = {s1_sign_r, {(EXP_W+MAN_W){1'b1}}};
        end else begin
            res_data_s = {s1_sign_r, res_exp_s, res_mant_s};
        end
    end

    // Pipeline registers with valid/ready advance; S2 output held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= {EXP_W{1'b0}};
            s1_mant_r    <= {MAN_W{1'b0}};
            s1_inc_r     <= 1'b0;
            s1_inexact_r <= 1'b0;
            s1_bad_rm_r  <= 1'b0;
            s1_special_r <= 1'b0;
            s2_valid_r   <= 1'b0;
            out_data_r   <= {(EXP_W+MAN_W+1){1'b0}};
            out_flags_r  <= 3'b000;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
                if (in_valid) begin
                    s1_sign_r    <= in_sign_s;
                    s1_exp_r     <= in_exp_s;
                    s1_mant_r    <= in_mant_s;
                    s1_inc_r     <= inc_s;
                    s1_inexact_r <= inexact_s;
                    s1_bad_rm_r  <= dec_s[1];
                    s1_special_r <= in_special_s;
                end
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    out_data_r  <= res_data_s;
                    out_flags_r <= {s1_bad_rm_r, ovf_s, s1_inexact_r};
                end
            end
        end
    end

    // Sticky flags; a clear coinciding with a transfer keeps that word's flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_flags_r <= 3'b000;
        end else if (out_xfer_s) begin
            acc_flags_r <= clr_flags ? out_flags_r : (acc_flags_r | out_flags_r);
        end else if (clr_flags) begin
            acc_flags_r <= 3'b000;
        end else begin
            acc_flags_r <= acc_flags_r;
        end
    end

endmodule

// File: tb/tb_dlfloat_round_pipe.sv
// Scoreboard bench for dlfloat_round_pipe: directed rounding cases, backpressure,
// random traffic, sticky-flag clearing and mid-operation reset.
module tb_dlfloat_round_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;
    logic [2:0]  acc_flags;
    logic        clr_flags;

    always #5 clk = ~clk;

    dlfloat_round_pipe #(.EXP_W(6), .MAN_W(9), .XTR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .acc_flags (acc_flags),
        .clr_flags (clr_flags)
    );

    logic [18:0] exp_q[$];
    logic [18:0] exp_pend;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [2:0]  acc_m;
    logic        hold_pend;
    logic [15:0] hold_data;
    logic [2:0]  hold_flags;
    logic        bp_en;
    logic        rnd_en;
    logic        rdy_val;
    logic [3:0]  pat = 4'b1001;
    int          pidx = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference rounding: exponent and mantissa treated as one 15-bit integer.
    function automatic logic [18:0] ref_round(input logic [19:0] d, input logic [2:0] rm);
        logic        sgn, g, r, s, lsb, nx, bad, inc, spec, ovf;
        logic [14:0] em, res;
        sgn  = d[19];
        em   = d[18:4];
        g    = d[3];
        r    = d[2];
        s    = d[1] | d[0];
        lsb  = d[4];
        nx   = g | r | s;
        bad  = (rm > 3'd4);
        spec = (em == 15'h7FFF);
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = !sgn && nx;
            3'd3:    inc = sgn && nx;
            3'd4:    inc = g;
            default: inc = g && (r || s || lsb);
        endcase
        if (spec) begin
            inc = 1'b0;
            nx  = 1'b0;
        end
        res = em + {14'd0, inc};
        ovf = !spec && (res == 15'h7FFF);
        return {sgn, res, bad, ovf, nx};
    endfunction

    task automatic send(input logic [19:0] d, input logic [2:0] rm, input logic [18:0] e);
        bit ok = 1'b0;
        in_data  = d;
        in_rm    = rm;
        exp_pend = e;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // out_ready source: fixed value, 1,0,0,1 pattern or random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_en) out_ready = pat[pidx % 4];
            else if (rnd_en) out_ready = 1'($urandom_range(0, 1));
            else out_ready = rdy_val;
            pidx++;
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_m     = 3'b000;
                hold_pend = 1'b0;
            end else begin
                check_eq("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
                check_eq("acc_flags", 32'(acc_flags), 32'(acc_m));
                if (hold_pend) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_data", 32'(out_data), 32'(hold_data));
                    check_eq("hold_flags", 32'(out_flags), 32'(hold_flags));
                end
                hold_pend  = out_valid && !out_ready;
                hold_data  = out_data;
                hold_flags = out_flags;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("out_data", 32'(out_data), 32'(e[18:3]));
                        check_eq("out_flags", 32'(out_flags), 32'(e[2:0]));
                        acc_m = clr_flags ? e[2:0] : (acc_m | e[2:0]);
                    end
                end else if (clr_flags) begin
                    acc_m = 3'b000;
                end
                if (in_valid && in_ready) exp_q.push_back(exp_pend);
            end
        end
    end

    initial begin
        logic [19:0] d;
        logic [2:0]  rm;
        rst = 1'b1; in_valid = 1'b0; in_data = 20'd0; in_rm = 3'd0; exp_pend = 19'd0;
        out_ready = 1'b1; clr_flags = 1'b0;
        bp_en = 1'b0; rnd_en = 1'b0; rdy_val = 1'b1;
        acc_m = 3'b000; hold_pend = 1'b0; hold_data = 16'd0; hold_flags = 3'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_flags", 32'(out_flags), 32'd0);
        check_eq("rst_acc_flags", 32'(acc_flags), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_rise", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // First word also checks the two-register latency.
        send({1'b0, 6'h20, 9'h001, 4'b1000}, 3'd0, {16'h4002, 3'b001});
        @(negedge clk);
        check_eq("lat_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_s2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        send({1'b0, 6'h20, 9'h002, 4'b1000}, 3'd0, {16'h4002, 3'b001});
        send({1'b0, 6'h10, 9'h1FF, 4'b1100}, 3'd0, {16'h2200, 3'b001});
        send({1'b1, 6'h05, 9'h010, 4'b0001}, 3'd2, {16'h8A10, 3'b001});
        send({1'b1, 6'h05, 9'h010, 4'b0001}, 3'd3, {16'h8A11, 3'b001});
        send({1'b1, 6'h05, 9'h010, 4'b0001}, 3'd1, {16'h8A10, 3'b001});
        send({1'b1, 6'h05, 9'h010, 4'b0001}, 3'd7, {16'h8A10, 3'b101});
        send({1'b0, 6'h05, 9'h010, 4'b0001}, 3'd2, {16'h0A11, 3'b001});
        send({1'b0, 6'h3F, 9'h1FE, 4'b1100}, 3'd0, {16'h7FFF, 3'b011});
        send({1'b0, 6'h3F, 9'h1FE, 4'b1000}, 3'd0, {16'h7FFE, 3'b001});
        send({1'b0, 6'h3F, 9'h1FE, 4'b1100}, 3'd1, {16'h7FFE, 3'b001});
        send({1'b1, 6'h3F, 9'h1FF, 4'b1111}, 3'd0, {16'hFFFF, 3'b000});
        send({1'b1, 6'h3F, 9'h1FF, 4'b1111}, 3'd5, {16'hFFFF, 3'b100});
        send({1'b0, 6'h20, 9'h002, 4'b1000}, 3'd4, {16'h4003, 3'b001});
        send({1'b0, 6'h20, 9'h002, 4'b0000}, 3'd2, {16'h4002, 3'b000});
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d  = 20'($urandom);
            rm = 3'($urandom_range(0, 7));
            send(d, rm, ref_round(d, rm));
        end
        drain();
        bp_en = 1'b0;

        rnd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d  = 20'($urandom);
            if (i % 7 == 0) d[18:4] = 15'h7FFF;
            if (i % 5 == 0) d[18:4] = 15'h7FFE;
            rm = 3'($urandom_range(0, 7));
            send(d, rm, ref_round(d, rm));
        end
        rnd_en = 1'b0;
        rdy_val = 1'b1;
        drain();

        // Clear coinciding with a flagged transfer keeps that word's flags.
        rdy_val = 1'b0;
        @(posedge clk); #1;
        send({1'b0, 6'h20, 9'h001, 4'b1000}, 3'd6, {16'h4002, 3'b101});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk); #1;
        clr_flags = 1'b1;
        rdy_val   = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        @(negedge clk);
        check_eq("clr_with_xfer", 32'(acc_flags), 32'd5);
        @(posedge clk); #1;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        @(negedge clk);
        check_eq("clr_alone", 32'(acc_flags), 32'd0);
        @(posedge clk); #1;

        // Reset with both stages full must discard them.
        rdy_val = 1'b0;
        @(posedge clk); #1;
        send({1'b0, 6'h11, 9'h055, 4'b1100}, 3'd0, ref_round({1'b0, 6'h11, 9'h055, 4'b1100}, 3'd0));
        send({1'b1, 6'h12, 9'h0AA, 4'b0100}, 3'd3, ref_round({1'b1, 6'h12, 9'h0AA, 4'b0100}, 3'd3));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_val = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("mid_rst_empty", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send({1'b0, 6'h01, 9'h003, 4'b1000}, 3'd0, {16'h0204, 3'b001});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
